// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencing controller:
// op codes, unit select encodings and controller state encoding.
package muldiv_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MFHI = 3'd3;
    localparam logic [2:0] OP_MFLO = 3'd4;
    localparam logic [2:0] OP_MTHI = 3'd5;
    localparam logic [2:0] OP_MTLO = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [1:0] MD_MUL = 2'b00;
    localparam logic [1:0] MD_DIV = 2'b01;

    localparam logic SEL_HIGH = 1'b1;
    localparam logic SEL_LOW  = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // NOP and the reserved code never touch the unit and never stall.
    function automatic logic is_real_op(input logic [2:0] code);
        return (code != OP_NOP) && (code != OP_RSVD);
    endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the HI/LO multiply/divide unit.
// Ports: Clk, Reset (sync, active-high); Op_Valid/Op_Code from decode;
// MUL_Flag completion from the unit; Stall back to decode; MUL_Start,
// MUL_SelMD, MUL_SelHL, MUL_Write unit controls; Rd_Valid for MFHI/MFLO;
// Busy while an operation or HI/LO commit is in flight.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Op_Valid,
    input  logic [2:0] Op_Code,
    input  logic       MUL_Flag,
    output logic       Stall,
    output logic       MUL_Start,
    output logic [1:0] MUL_SelMD,
    output logic       MUL_SelHL,
    output logic       MUL_Write,
    output logic       Rd_Valid,
    output logic       Busy
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    state_t     state;
    state_t     state_d;
    logic [3:0] cnt;
    logic [3:0] cnt_d;
    logic       req;

    assign req = Op_Valid && is_real_op(Op_Code);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        Stall     = 1'b0;
        MUL_Start = 1'b0;
        MUL_SelMD = MD_MUL;
        MUL_SelHL = SEL_LOW;
        MUL_Write = 1'b0;
        Rd_Valid  = 1'b0;
        Busy      = 1'b0;
        // Outputs are combinational, so gate them during reset too.
        if (Reset) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        unique case (Op_Code)
                            OP_MULT: begin
                                MUL_Start = 1'b1;
                                MUL_SelMD = MD_MUL;
                                state_d   = S_BUSY;
                                cnt_d     = MUL_CNT;
                            end
                            OP_DIV: begin
                                MUL_Start = 1'b1;
                                MUL_SelMD = MD_DIV;
                                state_d   = S_BUSY;
                                cnt_d     = DIV_CNT;
                            end
                            OP_MFHI: begin
                                Rd_Valid  = 1'b1;
                                MUL_SelHL = SEL_HIGH;
                            end
                            OP_MFLO: begin
                                Rd_Valid  = 1'b1;
                                MUL_SelHL = SEL_LOW;
                            end
                            OP_MTHI: begin
                                MUL_Write = 1'b1;
                                MUL_SelHL = SEL_HIGH;
                            end
                            OP_MTLO: begin
                                MUL_Write = 1'b1;
                                MUL_SelHL = SEL_LOW;
                            end
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    Busy  = 1'b1;
                    Stall = req;
                    if (cnt != 4'd0) begin
                        cnt_d = cnt - 4'd1;
                    end else if (MUL_Flag) begin
                        // Flag is only honoured once the minimum latency has run out.
                        state_d = S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    Busy    = 1'b1;
                    Stall   = req;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed scenarios plus random ops,
// expected outputs from a cycle-level behavioural model.
module tb_muldiv_ctrl;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 3;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_MULT = 3'd1;
    localparam logic [2:0] C_DIV  = 3'd2;
    localparam logic [2:0] C_MFHI = 3'd3;
    localparam logic [2:0] C_MFLO = 3'd4;
    localparam logic [2:0] C_MTHI = 3'd5;
    localparam logic [2:0] C_MTLO = 3'd6;
    localparam logic [2:0] C_RSVD = 3'd7;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Op_Valid = 1'b0;
    logic [2:0] Op_Code = 3'd0;
    logic       MUL_Flag = 1'b0;
    logic       Stall;
    logic       MUL_Start;
    logic [1:0] MUL_SelMD;
    logic       MUL_SelHL;
    logic       MUL_Write;
    logic       Rd_Valid;
    logic       Busy;

    muldiv_ctrl #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Op_Valid (Op_Valid),
        .Op_Code  (Op_Code),
        .MUL_Flag (MUL_Flag),
        .Stall    (Stall),
        .MUL_Start(MUL_Start),
        .MUL_SelMD(MUL_SelMD),
        .MUL_SelHL(MUL_SelHL),
        .MUL_Write(MUL_Write),
        .Rd_Valid (Rd_Valid),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    logic [7:0] exp_q[$];
    int tag_q[$];

    // Model: 0 = unit free, 1 = operation running, 2 = result commit cycle.
    int mode = 0;
    int elapsed = 0;
    int need = 0;

    task automatic cyc(input logic r, input logic v,
                       input logic [2:0] c, input logic f);
        logic stall, start, selhl, wr, rd, busy;
        logic [1:0] md;
        logic req;
        @(posedge Clk);
        #1;
        Reset = r;
        Op_Valid = v;
        Op_Code = c;
        MUL_Flag = f;
        stall = 0; start = 0; selhl = 0; wr = 0; rd = 0; busy = 0;
        md = 2'b00;
        req = v && (c != C_NOP) && (c != C_RSVD);
        if (r) begin
            mode = 0;
        end else if (mode == 0) begin
            if (req) begin
                if (c == C_MULT) begin
                    start = 1; md = 2'b00;
                    mode = 1; elapsed = 0; need = MUL_LAT;
                end else if (c == C_DIV) begin
                    start = 1; md = 2'b01;
                    mode = 1; elapsed = 0; need = DIV_LAT;
                end else if (c == C_MFHI || c == C_MFLO) begin
                    rd = 1; selhl = (c == C_MFHI);
                end else begin
                    wr = 1; selhl = (c == C_MTHI);
                end
            end
        end else if (mode == 1) begin
            busy = 1;
            stall = req;
            elapsed++;
            if (elapsed >= need && f) mode = 2;
        end else begin
            busy = 1;
            stall = req;
            mode = 0;
        end
        exp_q.push_back({stall, start, md, selhl, wr, rd, busy});
        tag_q.push_back(cycle);
        cycle++;
    endtask

    always @(negedge Clk) begin : monitor
        logic [7:0] e;
        logic [7:0] got;
        int t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {Stall, MUL_Start, MUL_SelMD, MUL_SelHL,
                   MUL_Write, Rd_Valid, Busy};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%b expected=%b (stall,start,selmd,selhl,write,rdvalid,busy)",
                         t, got, e);
            end
        end
    end

    initial begin
        // Reset for two cycles, then a MULT with flag high.
        cyc(1, 0, C_NOP, 0);
        cyc(1, 1, C_MULT, 1);
        cyc(0, 1, C_MULT, 1);
        repeat (4) cyc(0, 0, C_NOP, 1);
        // DIV then MFLO held until accepted.
        cyc(0, 1, C_DIV, 1);
        repeat (DIV_LAT + 2) cyc(0, 1, C_MFLO, 1);
        cyc(0, 0, C_NOP, 1);
        // MTHI then MTLO.
        cyc(0, 1, C_MTHI, 0);
        cyc(0, 1, C_MTLO, 0);
        cyc(0, 0, C_NOP, 0);
        // MULT with a late flag, MFHI waiting.
        cyc(0, 1, C_MULT, 0);
        repeat (MUL_LAT + 5) cyc(0, 1, C_MFHI, 0);
        repeat (3) cyc(0, 1, C_MFHI, 1);
        // Reset during BUSY with MFHI pending.
        cyc(0, 1, C_MULT, 0);
        cyc(0, 1, C_MFHI, 0);
        cyc(1, 1, C_MFHI, 0);
        cyc(0, 1, C_MFHI, 0);
        cyc(0, 0, C_NOP, 0);
        // NOP/reserved in BUSY, MULT arriving in COMMIT.
        cyc(0, 1, C_MULT, 1);
        cyc(0, 1, C_RSVD, 1);
        cyc(0, 1, C_NOP, 1);
        cyc(0, 1, C_MULT, 1);
        cyc(0, 1, C_MULT, 1);
        repeat (5) cyc(0, 0, C_NOP, 1);
        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 79) == 0,
                $urandom_range(0, 3) != 0,
                3'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0);
        end
        repeat (4) cyc(0, 0, C_NOP, 1);
        repeat (2) @(negedge Clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
